// File: rtl/nvram_transfer_ctrl_pkg.sv
// Shared definitions for the NVRAM transfer controller.
//   NVRAM_ADDR_W / NVRAM_DATA_W / NVRAM_HOST_W : default geometry of the CPU NVRAM
//     (256 words of 4 bits) and of the host save/load byte stream.
//   xfer_state_t : transfer FSM state encoding.
package nvram_transfer_ctrl_pkg;

  localparam int NVRAM_ADDR_W = 8;
  localparam int NVRAM_DATA_W = 4;
  localparam int NVRAM_HOST_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SAVE_ADDR = 3'd2,
    ST_SAVE_WAIT = 3'd3,
    ST_SAVE_OUT  = 3'd4,
    ST_FINISH    = 3'd5
  } xfer_state_t;

endpackage

// File: rtl/nvram_transfer_ctrl.sv
// NVRAM transfer controller: owns the single NVRAM port and shares it between the
// game CPU (in IDLE) and the host save/load stream (LOAD restores a full image,
// SAVE streams the full image out). Tracks whether the CPU has modified NVRAM
// since the last completed transfer.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   cpu_address/cpu_write/cpu_data    CPU access, passed to NVRAM only in IDLE
//   cpu_q                             NVRAM read data forwarded to the CPU
//   load_start/save_start/xfer_abort  transfer control pulses
//   load_valid/load_data/load_ready   host -> NVRAM byte stream (valid/ready)
//   save_valid/save_data/save_ready   NVRAM -> host byte stream (valid/ready)
//   busy/done/dirty                   status
//   mem_address/mem_write/mem_data    to the NVRAM array
//   mem_q                             from the NVRAM array (1-cycle read latency)
module nvram_transfer_ctrl
  import nvram_transfer_ctrl_pkg::*;
#(
  parameter int ADDR_W = NVRAM_ADDR_W,
  parameter int DATA_W = NVRAM_DATA_W,
  parameter int HOST_W = NVRAM_HOST_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_data,
  output logic [DATA_W-1:0] cpu_q,
  input  logic              load_start,
  input  logic              save_start,
  input  logic              xfer_abort,
  input  logic              load_valid,
  input  logic [HOST_W-1:0] load_data,
  output logic              load_ready,
  output logic              save_valid,
  output logic [HOST_W-1:0] save_data,
  input  logic              save_ready,
  output logic              busy,
  output logic              done,
  output logic              dirty,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_q
);

  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  xfer_state_t       state;
  logic [ADDR_W-1:0] ptr;

  function automatic logic [HOST_W-1:0] zext_word(input logic [DATA_W-1:0] d);
    logic [HOST_W-1:0] r;
    r = '0;
    r[DATA_W-1:0] = d;
    return r;
  endfunction

  // Host bytes carry the NVRAM word in their low bits; the rest is don't-care.
  generate
    if (HOST_W > DATA_W) begin : g_host_pad
      logic unused_load_hi;
      assign unused_load_hi = ^load_data[HOST_W-1:DATA_W];
    end
  endgenerate

  assign cpu_q = mem_q;

  // NVRAM port mux: CPU owns the port in IDLE, the transfer pointer otherwise.
  // CPU writes are gated by reset_n so nothing is written while reset is held.
  always_comb begin
    mem_address = ptr;
    mem_write   = 1'b0;
    mem_data    = load_data[DATA_W-1:0];
    if (state == ST_IDLE) begin
      mem_address = cpu_address;
      mem_write   = cpu_write && reset_n;
      mem_data    = cpu_data;
    end else if (state == ST_LOAD) begin
      // Abort wins over a same-cycle handshake: the byte is not written.
      mem_write = load_valid && load_ready && !xfer_abort;
    end
  end

  // Transfer FSM; every status output is registered alongside the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      load_ready <= 1'b0;
      save_valid <= 1'b0;
      save_data  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dirty      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          ptr <= '0;
          if (cpu_write) dirty <= 1'b1;
          // LOAD wins when both starts arrive together.
          if (load_start) begin
            state      <= ST_LOAD;
            load_ready <= 1'b1;
            busy       <= 1'b1;
          end else if (save_start) begin
            state <= ST_SAVE_ADDR;
            busy  <= 1'b1;
          end
        end

        ST_LOAD: begin
          if (xfer_abort) begin
            state      <= ST_IDLE;
            load_ready <= 1'b0;
            busy       <= 1'b0;
            ptr        <= '0;
          end else if (load_valid && load_ready) begin
            ptr <= ptr + ADDR_W'(1);
            if (ptr == PTR_LAST) begin
              state      <= ST_FINISH;
              load_ready <= 1'b0;
              done       <= 1'b1;
            end
          end
        end

        ST_SAVE_ADDR: begin
          if (xfer_abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            ptr   <= '0;
          end else begin
            state <= ST_SAVE_WAIT;
          end
        end

        // mem_q now reflects the address presented in SAVE_ADDR.
        ST_SAVE_WAIT: begin
          if (xfer_abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            ptr   <= '0;
          end else begin
            state      <= ST_SAVE_OUT;
            save_valid <= 1'b1;
            save_data  <= zext_word(mem_q);
          end
        end

        // save_data is only reloaded in SAVE_WAIT, so it holds while stalled.
        ST_SAVE_OUT: begin
          if (xfer_abort) begin
            state      <= ST_IDLE;
            save_valid <= 1'b0;
            busy       <= 1'b0;
            ptr        <= '0;
          end else if (save_ready) begin
            save_valid <= 1'b0;
            if (ptr == PTR_LAST) begin
              state <= ST_FINISH;
              done  <= 1'b1;
            end else begin
              ptr   <= ptr + ADDR_W'(1);
              state <= ST_SAVE_ADDR;
            end
          end
        end

        // Image is now in sync with the host; CPU writes here are dropped.
        ST_FINISH: begin
          dirty <= 1'b0;
          busy  <= 1'b0;
          ptr   <= '0;
          state <= ST_IDLE;
        end

        default: begin
          state      <= ST_IDLE;
          load_ready <= 1'b0;
          save_valid <= 1'b0;
          busy       <= 1'b0;
          ptr        <= '0;
        end
      endcase
    end
  end

endmodule
